// File: rtl/uart_tx_if.sv
// Request/serial bundle for uart_tx: parallel byte request toward the transmitter,
// serial line and status back from it.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  busy;
    logic                  ready;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  TX_OUT, busy, ready
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output TX_OUT, busy, ready
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter, one serial bit per CLK: start, LSB-first data, optional parity, stop.
// Define UART_TX_HOLD_BUF_EN for a one-entry hold buffer giving zero-gap back-to-back frames.
//
// state    | meaning
// S_IDLE   | line high, waiting for a request (or a held one)
// S_START  | start bit (0) on TX_OUT
// S_DATA   | data bit bit_cnt on TX_OUT
// S_PARITY | parity bit of the latched byte on TX_OUT
// S_STOP   | stop bit (1) on TX_OUT
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic      CLK,
    input  logic      RST,
    uart_tx_if.slave  bus
);

    localparam int            CW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [CW-1:0]         bit_cnt, bit_cnt_nxt;
    logic                  tx_q, tx_nxt;
    logic                  load;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_par_en;
    logic                  load_par_typ;
    logic                  par_bit;
    logic                  busy_w;
    logic                  accept;

`ifdef UART_TX_HOLD_BUF_EN
    logic                  hold_full, hold_full_nxt;
    logic                  hold_capture;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_par_en;
    logic                  hold_par_typ;
`endif

    assign busy_w  = (state != S_IDLE);
    assign par_bit = par_typ_q ? ~^data_q : ^data_q;

`ifdef UART_TX_HOLD_BUF_EN
    assign bus.ready = ~hold_full;
`else
    assign bus.ready = ~busy_w;
`endif

    assign accept     = bus.Data_Valid & bus.ready;
    assign bus.busy   = busy_w;
    assign bus.TX_OUT = tx_q;

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        tx_nxt       = tx_q;
        load         = 1'b0;
        load_data    = bus.P_DATA;
        load_par_en  = bus.PAR_EN;
        load_par_typ = bus.PAR_TYP;
`ifdef UART_TX_HOLD_BUF_EN
        hold_full_nxt = hold_full;
        hold_capture  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                tx_nxt = 1'b1;
`ifdef UART_TX_HOLD_BUF_EN
                // A request captured during the last STOP cycle waits here for one cycle
                if (hold_full) begin
                    load          = 1'b1;
                    load_data     = hold_data;
                    load_par_en   = hold_par_en;
                    load_par_typ  = hold_par_typ;
                    hold_full_nxt = 1'b0;
                    state_nxt     = S_START;
                    tx_nxt        = 1'b0;
                end else
`endif
                if (accept) begin
                    load      = 1'b1;
                    state_nxt = S_START;
                    tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                state_nxt   = S_DATA;
                bit_cnt_nxt = '0;
                tx_nxt      = data_q[0];
            end
            S_DATA: begin
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt_nxt = '0;
                    if (par_en_q) begin
                        state_nxt = S_PARITY;
                        tx_nxt    = par_bit;
                    end else begin
                        state_nxt = S_STOP;
                        tx_nxt    = 1'b1;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    tx_nxt      = data_q[bit_cnt_nxt];
                end
            end
            S_PARITY: begin
                state_nxt = S_STOP;
                tx_nxt    = 1'b1;
            end
            S_STOP: begin
                state_nxt = S_IDLE;
                tx_nxt    = 1'b1;
`ifdef UART_TX_HOLD_BUF_EN
                if (hold_full) begin
                    load          = 1'b1;
                    load_data     = hold_data;
                    load_par_en   = hold_par_en;
                    load_par_typ  = hold_par_typ;
                    hold_full_nxt = 1'b0;
                    state_nxt     = S_START;
                    tx_nxt        = 1'b0;
                end
`endif
            end
            default: begin
                state_nxt   = S_IDLE;
                bit_cnt_nxt = '0;
                tx_nxt      = 1'b1;
            end
        endcase
`ifdef UART_TX_HOLD_BUF_EN
        if (accept && busy_w) begin
            hold_capture  = 1'b1;
            hold_full_nxt = 1'b1;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            tx_q      <= 1'b1;
            bit_cnt   <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx_q    <= tx_nxt;
            bit_cnt <= bit_cnt_nxt;
            if (load) begin
                data_q    <= load_data;
                par_en_q  <= load_par_en;
                par_typ_q <= load_par_typ;
            end
        end
    end

`ifdef UART_TX_HOLD_BUF_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_full    <= 1'b0;
            hold_data    <= '0;
            hold_par_en  <= 1'b0;
            hold_par_typ <= 1'b0;
        end else begin
            hold_full <= hold_full_nxt;
            if (hold_capture) begin
                hold_data    <= bus.P_DATA;
                hold_par_en  <= bus.PAR_EN;
                hold_par_typ <= bus.PAR_TYP;
            end
        end
    end
`endif

endmodule
